// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake states and the memory port arbiter FSM encoding.
package cpu_types_pkg;

    // RAM model handshake, shared by the RAM model and everything that talks to it.
    typedef enum logic [1:0] {
        RAM_FREE   = 2'd0,
        RAM_BUSY   = 2'd1,
        RAM_ACCESS = 2'd2,
        RAM_ERROR  = 2'd3
    } ramstate_t;

    // Memory port arbiter states: idle, instruction grant, data grant.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

    // Width of the consecutive-data-grant counter; covers MAX_DSTREAK up to 15.
    localparam int DSTREAK_W = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one RAM port between the instruction and data
// requesters. One transaction at a time; data wins unless an instruction
// request has already watched MAX_DSTREAK data grants go by.
module mem_port_arbiter
    import cpu_types_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_DSTREAK = 4
) (
    input  logic              CLK,
    input  logic              RST,
    // instruction requester
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] iload,
    output logic              iwait,
    // data requester
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic [DATA_W-1:0] dload,
    output logic              dwait,
    // CPU halt, blocks new instruction grants
    input  logic              halt,
    // RAM port
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  ramstate_t         ramstate,
    // sticky RAM error flag
    output logic              err
);

    localparam logic [DSTREAK_W-1:0] STREAK_MAX = DSTREAK_W'(MAX_DSTREAK);

    arb_state_t           state_q, state_d;
    logic [DSTREAK_W-1:0] dstreak_q, dstreak_d;
    logic                 err_q, err_d;

    logic dreq;
    logic ireq;

    // Request qualification: halt only gates new instruction grants.
    assign dreq = dREN | dWEN;
    assign ireq = iREN & ~halt;

    // State, fairness counter and sticky error register.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values computed before this edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            dstreak_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dstreak_q <= dstreak_d;
            err_q     <= err_d;
        end
    end

    // Next-state decision plus RAM drive and wait/load muxing from the current grant.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave a latch behind.
        state_d   = state_q;
        dstreak_d = dstreak_q;
        err_d     = err_q;
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        ramaddr   = '0;
        ramstore  = '0;
        iwait     = 1'b1;
        dwait     = 1'b1;
        iload     = '0;
        dload     = '0;

        // A RAM error while holding either grant is remembered; the grant is kept for a retry.
        if (state_q != IDLE && ramstate == RAM_ERROR) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                // The streak only counts data grants an instruction request actually waited through.
                if (!ireq) begin
                    dstreak_d = '0;
                end
                if (ireq && dstreak_q == STREAK_MAX) begin
                    state_d = GNT_I;
                end else if (dreq) begin
                    state_d = GNT_D;
                end else if (ireq) begin
                    state_d = GNT_I;
                end
            end

            GNT_I: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                // halt is ignored here so an access already granted still finishes.
                if (!iREN) begin
                    state_d = IDLE;
                end else if (ramstate == RAM_ACCESS) begin
                    iwait     = 1'b0;
                    iload     = ramload;
                    dstreak_d = '0;
                    state_d   = IDLE;
                end
            end

            GNT_D: begin
                // A simultaneous read and write request is served as a write.
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                if (!dreq) begin
                    state_d = IDLE;
                end else if (ramstate == RAM_ACCESS) begin
                    dwait   = 1'b0;
                    dload   = ramload;
                    state_d = IDLE;
                    if (ireq && dstreak_q < STREAK_MAX) begin
                        dstreak_d = dstreak_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign err = err_q;

endmodule
